multicycle_main_control: RTL
============================

// Module: multicycle_main_control
// PURPOSE
// Main control FSM of the multicycle MIPS datapath; the issuing end of the 3-bit ALUop interface consumed by the ALU control decoder.
// Decodes the latched opcode and sequences fetch/decode/execute/memory/writeback over several cycles.
// Per state it drives all datapath selects and enables, plus ALUop (3'b111 = "use function code").
// Adds a memory-ready handshake, an illegal-opcode flag and a retired-instruction counter.
// PARAMETERS
// CNT_W    32   width of retired-instruction counter instr_count
// PORTS
// clk          in   1      single clock, all state on rising edge
// rst_n        in   1      asynchronous, active-low reset
// opcode       in   6      IR[31:26], stable from DECODE until instruction completes
// zero         in   1      ALU zero flag (beq resolution)
// mem_ready    in   1      memory access completes this cycle
// mem_read     out  1      memory read request
// mem_write    out  1      memory write request
// i_or_d       out  1      0=PC addresses memory, 1=ALUOut
// ir_write     out  1      load IR
// pc_en        out  1      load PC
// pc_source    out  2      00=ALU result, 01=ALUOut, 10=jump target
// alu_src_a    out  1      0=PC, 1=reg A
// alu_src_b    out  2      00=reg B, 01=const 4, 10=ext imm, 11=sign-ext imm<<2
// imm_zext     out  1      1=zero-extend immediate (ori)
// alu_op       out  3      000 ADD, 101 SUB, 001 OR, 111 FUNC
// reg_dst      out  1      0=rt, 1=rd
// mem_to_reg   out  1      0=ALUOut, 1=MDR
// reg_write    out  1      register file write enable
// instr_done   out  1      one-cycle pulse when an instruction retires
// illegal_op   out  1      one-cycle pulse on unsupported opcode
// instr_count  out  CNT_W  retired-instruction count
// BEHAVIOUR
// - rst_n low: state=START, instr_count=0, every output 0 (async, takes effect mid-access; mem_read/mem_write drop at once).
// - Outputs are Moore decodes of state. Exceptions: ir_write, pc_en, illegal_op and instr_done also depend on inputs as stated below.
// - Any output not listed for a state is 0.
// - START: all outputs 0. Next state FETCH.
// - FETCH: mem_read=1, alu_src_b=01, alu_op=ADD, ir_write=pc_en=mem_ready. Next state DECODE if mem_ready, else stay.
// - DECODE: alu_src_b=11, alu_op=ADD (branch target precompute). Next state by opcode:
//     000000 -> R_EXEC; 100011 (lw) or 101011 (sw) -> MEM_ADDR; 000100 -> BRANCH;
//     000010 -> JUMP; 001000 (addi) or 001101 (ori) -> I_EXEC; else -> FETCH with illegal_op=1.
// - MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next state MEM_RD (lw) or MEM_WR (sw).
// - MEM_RD: mem_read=1, i_or_d=1. Stay until mem_ready, then MEM_WB.
// - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
// - MEM_WR: mem_write=1, i_or_d=1. Stay until mem_ready, then FETCH.
// - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=FUNC. Next state R_WB.
// - R_WB: reg_write=1, reg_dst=1. Next state FETCH.
// - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_en=zero. Next state FETCH.
// - JUMP: pc_source=10, pc_en=1. Next state FETCH.
// - I_EXEC: alu_src_a=1, alu_src_b=10. addi: ADD, imm_zext=0. ori: OR, imm_zext=1. Next state I_WB.
// - I_WB: reg_write=1, reg_dst=0. Next state FETCH.
// - instr_done=1 in the last cycle of each instruction: MEM_WB; MEM_WR & mem_ready; R_WB; BRANCH; JUMP; I_WB.
// - Illegal opcodes do not assert instr_done. PC already advanced in FETCH, so the instruction is skipped.
// - instr_count += 1 on the clock edge where instr_done=1; wraps modulo 2^CNT_W.
// - Zero-wait cycle counts: lw 5, sw 4, R 4, addi/ori 4, beq 3, j 3. Each mem_ready=0 cycle adds one.
// - mem_read/mem_write are held stable while waiting. Never both high.
// STRUCTURE
// - Shared package/include mips_ctrl_pkg: opcode constants, ALUOP_ADD/SUB/OR/FUNC, state encoding (4-bit), pc_source/alu_src_b codes.
// - One sub-module: mips_opcode_class (combinational opcode -> one-hot class {rtype,lw,sw,beq,j,addi,ori,illegal}).
// - Top holds state register, next-state logic, output decode and counter.
// TESTING
// - Reset, then release, mem_ready=1 -> START all-zero for 1 cycle; FETCH shows mem_read=1, alu_src_b=01, alu_op=000, pc_en=ir_write=1.
// - lw (100011), mem_ready=1 -> FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB. mem_to_reg=reg_write=1 in cycle 5; instr_done 1 cycle; instr_count 0->1.
// - R-type (000000) -> alu_op=111 in R_EXEC; reg_dst=reg_write=1 in R_WB; 4 cycles. Follow with ori (001101): alu_op=001, imm_zext=1.
// - beq (000100) with zero=0 then repeated with zero=1 -> pc_en 0 then 1 in BRANCH; alu_op=101, pc_source=01.
// - mem_ready low 3 cycles in FETCH and 2 in MEM_WR (sw) -> state holds, mem_read/mem_write steady, ir_write=pc_en=0; proceeds the cycle mem_ready=1.
// - opcode 111111 -> illegal_op pulse in DECODE, back to FETCH, count unchanged. rst_n low mid-MEM_WR -> mem_write=0 at once, instr_count=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, ALUop, select codes, FSM states.
// Pure declarations; no latency, no flow control.
// Imported by the opcode classifier, the control top and the bus interface users.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALUOP_ADD  = 3'b000;
    localparam logic [2:0] ALUOP_SUB  = 3'b101;
    localparam logic [2:0] ALUOP_OR   = 3'b001;
    localparam logic [2:0] ALUOP_FUNC = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    typedef enum logic [3:0] {
        ST_START    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_I_EXEC   = 4'd11,
        ST_I_WB     = 4'd12
    } state_e;

    typedef struct packed {
        logic rtype;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic addi;
        logic ori;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Control bus between the main control FSM and the datapath/memory side.
// No latency of its own; mem_ready is the memory's completion handshake.
// master = control FSM, slave = datapath/memory.
interface multicycle_main_control_if #(parameter int CNT_W = 32);

    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             ir_write;
    logic             pc_en;
    logic [1:0]       pc_source;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             imm_zext;
    logic [2:0]       alu_op;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
               alu_src_a, alu_src_b, imm_zext, alu_op, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
               alu_src_a, alu_src_b, imm_zext, alu_op, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op, instr_count
    );

endinterface

// File: rtl/mips_opcode_class.sv
// Opcode to one-hot instruction class; anything unsupported lands in illegal.
// Purely combinational, zero latency.
// No flow control.
module mips_opcode_class
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    output op_class_t  cls_o
);

    always_comb begin
        cls_o = '0;
        case (opcode_i)
            OP_RTYPE: cls_o.rtype   = 1'b1;
            OP_LW:    cls_o.lw      = 1'b1;
            OP_SW:    cls_o.sw      = 1'b1;
            OP_BEQ:   cls_o.beq     = 1'b1;
            OP_J:     cls_o.j       = 1'b1;
            OP_ADDI:  cls_o.addi    = 1'b1;
            OP_ORI:   cls_o.ori     = 1'b1;
            default:  cls_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback and counts retirements.
// 3-5 cycles per instruction at zero wait; each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds one.
// Memory stalls hold state with mem_read/mem_write steady; no other backpressure.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_main_control_if.master ctrl
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    op_class_t        cls;

    mips_opcode_class u_class (
        .opcode_i (ctrl.opcode),
        .cls_o    (cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_START;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ctrl.mem_read   = 1'b0;
        ctrl.mem_write  = 1'b0;
        ctrl.i_or_d     = 1'b0;
        ctrl.ir_write   = 1'b0;
        ctrl.pc_en      = 1'b0;
        ctrl.pc_source  = PCSRC_ALU;
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_REGB;
        ctrl.imm_zext   = 1'b0;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b0;
        ctrl.instr_done = 1'b0;
        ctrl.illegal_op = 1'b0;

        case (state_q)
            ST_START: state_d = ST_FETCH;

            // PC+4 is written in the same cycle the IR captures the fetched word.
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = ctrl.mem_ready;
                ctrl.pc_en     = ctrl.mem_ready;
                if (ctrl.mem_ready) state_d = ST_DECODE;
            end

            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_BRIMM;
                ctrl.alu_op    = ALUOP_ADD;
                if (cls.rtype)              state_d = ST_R_EXEC;
                else if (cls.lw || cls.sw)  state_d = ST_MEM_ADDR;
                else if (cls.beq)           state_d = ST_BRANCH;
                else if (cls.j)             state_d = ST_JUMP;
                else if (cls.addi || cls.ori) state_d = ST_I_EXEC;
                else begin
                    ctrl.illegal_op = 1'b1;
                    state_d         = ST_FETCH;
                end
            end

            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                if (cls.lw)      state_d = ST_MEM_RD;
                else if (cls.sw) state_d = ST_MEM_WR;
                else             state_d = ST_FETCH;
            end

            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (ctrl.mem_ready) state_d = ST_MEM_WB;
            end

            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = ST_FETCH;
            end

            ST_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = ctrl.mem_ready;
                if (ctrl.mem_ready) state_d = ST_FETCH;
            end

            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_FUNC;
                state_d        = ST_R_WB;
            end

            ST_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = ST_FETCH;
            end

            // Target was precomputed into ALUOut during DECODE.
            ST_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_REGB;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_source  = PCSRC_ALUOUT;
                ctrl.pc_en      = ctrl.zero;
                ctrl.instr_done = 1'b1;
                state_d         = ST_FETCH;
            end

            ST_JUMP: begin
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.pc_en      = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = ST_FETCH;
            end

            ST_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                if (cls.ori) begin
                    ctrl.alu_op   = ALUOP_OR;
                    ctrl.imm_zext = 1'b1;
                end else begin
                    ctrl.alu_op   = ALUOP_ADD;
                end
                state_d = ST_I_WB;
            end

            ST_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = ST_FETCH;
            end

            default: state_d = ST_START;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (ctrl.instr_done) count_d = count_q + CNT_W'(1);
    end

    assign ctrl.instr_count = count_q;

endmodule
